// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point adder/subtractor.
interface fp_addsub_pipe_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] arg_0;
  logic [W-1:0] arg_1;
  logic         arg_2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ret_0;
  logic [3:0]   ret_1;

  modport master (
    output in_valid, arg_0, arg_1, arg_2, out_ready,
    input  in_ready, out_valid, ret_0, ret_1
  );

  modport slave (
    input  in_valid, arg_0, arg_1, arg_2, out_ready,
    output in_ready, out_valid, ret_0, ret_1
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point add/sub: unpack/swap, align, add/sub,
// normalise/round/pack. One global stall derived from the output register.
module fp_addsub_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  fp_addsub_pipe_if.slave io
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 1;
  localparam int F  = FRAC_W + 4;
  localparam int A  = F - 1;
  localparam int XW = (EXP_W + 1 > $clog2(F + 1) + 1) ? EXP_W + 1 : $clog2(F + 1) + 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  logic         adv;
  logic         out_valid_q;
  logic [W-1:0] ret_0_q;
  logic [3:0]   ret_1_q;

  assign adv          = !out_valid_q || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.ret_0     = ret_0_q;
  assign io.ret_1     = ret_1_q;

  // ---------------- S1: unpack / swap / specials ----------------
  logic              xs, ys, ls, swap, sub1;
  logic [EXP_W-1:0]  xe, ye, le, re;
  logic [FRAC_W-1:0] xf, yf, lf, rf;
  logic              x_nan, y_nan, x_inf, y_inf;
  logic              spec1, inv1;
  logic [W-1:0]      sres1;

  assign {xs, xe, xf} = io.arg_0;
  assign ys    = io.arg_1[W-1] ^ io.arg_2;
  assign ye    = io.arg_1[W-2:FRAC_W];
  assign yf    = io.arg_1[FRAC_W-1:0];
  assign x_nan = (&xe) && (xf != '0);
  assign y_nan = (&ye) && (yf != '0);
  assign x_inf = (&xe) && (xf == '0);
  assign y_inf = (&ye) && (yf == '0);
  assign swap  = {ye, yf} > {xe, xf};
  assign sub1  = xs ^ ys;

  always_comb begin
    ls = swap ? ys : xs;
    le = swap ? ye : xe;
    lf = swap ? yf : xf;
    re = swap ? xe : ye;
    rf = swap ? xf : yf;
    spec1 = 1'b1;
    inv1  = 1'b0;
    sres1 = QNAN;
    if (x_nan || y_nan) begin
      sres1 = QNAN;
    end else if (x_inf && y_inf && sub1) begin
      inv1 = 1'b1;
    end else if (x_inf) begin
      sres1 = {xs, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (y_inf) begin
      sres1 = {ys, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      spec1 = 1'b0;
    end
  end

  logic             s1_valid, s1_spec, s1_inv, s1_sign, s1_sub;
  logic [W-1:0]     s1_sres;
  logic [EXP_W-1:0] s1_el, s1_er;
  logic [M-1:0]     s1_ml, s1_mr;

  // ---------------- S2: align ----------------
  logic [XW-1:0]  d;
  logic [2*A-1:0] ext;

  always_comb begin
    d = XW'(s1_el) - XW'(s1_er);
    if (d > XW'(A)) d = XW'(A);
    ext = {s1_mr, 2'b00, {A{1'b0}}} >> d;
  end

  logic             s2_valid, s2_spec, s2_inv, s2_sign, s2_sub;
  logic [W-1:0]     s2_sres;
  logic [EXP_W-1:0] s2_exp;
  logic [F-1:0]     s2_lf, s2_rf;

  // ---------------- S3: add / sub ----------------
  logic             s3_valid, s3_spec, s3_inv, s3_sign, s3_sub;
  logic [W-1:0]     s3_sres;
  logic [EXP_W-1:0] s3_exp;
  logic [F:0]       s3_sum;

  // ---------------- S4: normalise / round / pack ----------------
  logic [XW-1:0]     lz, lim, sh, e_n, e_r;
  logic [F-1:0]      nrm;
  logic [M:0]        rnd;
  logic              g, r, st, inc, hid;
  logic [FRAC_W-1:0] frac_o;
  logic [W-1:0]      res;
  logic [3:0]        flg;

  always_comb begin
    lz = XW'(F);
    for (int unsigned i = 0; i < F; i++) begin
      if (s3_sum[i]) lz = XW'(F - 1 - i);
    end
    lim = XW'(s3_exp) - XW'(1);
    sh  = '0;
    // Left shift is capped so the exponent never drops below 1; what is left
    // unnormalised at exponent 1 is the subnormal case.
    if (s3_sum[F]) begin
      nrm = {s3_sum[F:2], s3_sum[1] | s3_sum[0]};
      e_n = XW'(s3_exp) + XW'(1);
    end else begin
      sh  = (lz < lim) ? lz : lim;
      nrm = s3_sum[F-1:0] << sh;
      e_n = XW'(s3_exp) - sh;
    end
    g   = nrm[2];
    r   = nrm[1];
    st  = nrm[0];
    inc = g & (r | st | nrm[3]);
    rnd = {1'b0, nrm[F-1:3]} + (M+1)'(inc);
    e_r    = rnd[M] ? e_n + XW'(1) : e_n;
    frac_o = rnd[M] ? '0 : rnd[FRAC_W-1:0];
    hid    = rnd[M] | rnd[M-1];

    res = {s3_sign, e_r[EXP_W-1:0], frac_o};
    flg = {3'b000, g | r | st};
    if (s3_spec) begin
      res = s3_sres;
      flg = {s3_inv, 3'b000};
    end else if (s3_sum == '0) begin
      res = {s3_sign & ~s3_sub, {(W-1){1'b0}}};
      flg = '0;
    end else if (e_r >= XW'((1 << EXP_W) - 1)) begin
      res = {s3_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flg = 4'b0101;
    end else if (!hid) begin
      res = {s3_sign, {(W-1){1'b0}}};
      flg = 4'b0011;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0; s1_spec <= 1'b0; s1_inv <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0;
      s1_sres  <= '0;   s1_el   <= '0;   s1_er  <= '0;   s1_ml   <= '0;   s1_mr  <= '0;
      s2_valid <= 1'b0; s2_spec <= 1'b0; s2_inv <= 1'b0; s2_sign <= 1'b0; s2_sub <= 1'b0;
      s2_sres  <= '0;   s2_exp  <= '0;   s2_lf  <= '0;   s2_rf   <= '0;
      s3_valid <= 1'b0; s3_spec <= 1'b0; s3_inv <= 1'b0; s3_sign <= 1'b0; s3_sub <= 1'b0;
      s3_sres  <= '0;   s3_exp  <= '0;   s3_sum <= '0;
      out_valid_q <= 1'b0;
      ret_0_q     <= '0;
      ret_1_q     <= '0;
    end else if (adv) begin
      s1_valid <= io.in_valid;
      s1_spec  <= spec1;
      s1_inv   <= inv1;
      s1_sres  <= sres1;
      s1_sign  <= ls;
      s1_sub   <= sub1;
      s1_el    <= (le == '0) ? EXP_W'(1) : le;
      s1_er    <= (re == '0) ? EXP_W'(1) : re;
      s1_ml    <= {le != '0, lf};
      s1_mr    <= {re != '0, rf};

      s2_valid <= s1_valid;
      s2_spec  <= s1_spec;
      s2_inv   <= s1_inv;
      s2_sres  <= s1_sres;
      s2_sign  <= s1_sign;
      s2_sub   <= s1_sub;
      s2_exp   <= s1_el;
      s2_lf    <= {s1_ml, 3'b000};
      s2_rf    <= {ext[2*A-1:A], |ext[A-1:0]};

      s3_valid <= s2_valid;
      s3_spec  <= s2_spec;
      s3_inv   <= s2_inv;
      s3_sres  <= s2_sres;
      s3_sign  <= s2_sign;
      s3_sub   <= s2_sub;
      s3_exp   <= s2_exp;
      s3_sum   <= s2_sub ? ({1'b0, s2_lf} - {1'b0, s2_rf}) : ({1'b0, s2_lf} + {1'b0, s2_rf});

      out_valid_q <= s3_valid;
      if (s3_valid) begin
        ret_0_q <= res;
        ret_1_q <= flg;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (FP16): directed vectors plus random traffic scored
// against a real-arithmetic reference with random back-pressure and reset.
module tb_fp_addsub_pipe;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int EMIN   = 1 - BIAS;
  localparam int EMAX   = BIAS;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();
  fp_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (.clk(clk), .rst(rst), .io(bus));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_out    = 0;
  logic [W+3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real v;
    v = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) v = v * 2.0;
    else        for (int i = 0; i < -n; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic real value(input logic [W-1:0] v);
    int  e, f;
    real m;
    e = int'(v[W-2:FRAC_W]);
    f = int'(v[FRAC_W-1:0]);
    if (e == 0) m = real'(f) * pow2(EMIN - FRAC_W);
    else        m = real'(f + (1 << FRAC_W)) * pow2(e - BIAS - FRAC_W);
    return v[W-1] ? -m : m;
  endfunction

  // Exact sum in double precision, then rounded to nearest-even at FP16 precision.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] y;
    real v, mag, q, m, r;
    int  e, e2, n;
    logic s, inx;
    y = {b[W-1] ^ sub, b[W-2:0]};
    if (((&a[W-2:FRAC_W]) && a[FRAC_W-1:0] != '0) || ((&y[W-2:FRAC_W]) && y[FRAC_W-1:0] != '0))
      return {QNAN, 4'b0000};
    if ((&a[W-2:FRAC_W]) && (&y[W-2:FRAC_W]))
      return (a[W-1] != y[W-1]) ? {QNAN, 4'b1000} : {a, 4'b0000};
    if (&a[W-2:FRAC_W]) return {a, 4'b0000};
    if (&y[W-2:FRAC_W]) return {y, 4'b0000};
    v = value(a) + value(y);
    if (v == 0.0) return {a[W-1] & y[W-1], {(W-1){1'b0}}, 4'b0000};
    s   = (v < 0.0);
    mag = s ? -v : v;
    e = 0;
    while (mag >= pow2(e + 1)) e++;
    while (mag < pow2(e)) e--;
    q   = pow2(((e < EMIN) ? EMIN : e) - FRAC_W);
    m   = mag / q;
    n   = $rtoi(m);
    inx = (m != real'(n));
    if ((m - real'(n) > 0.5) || ((m - real'(n) == 0.5) && (n % 2 == 1))) n++;
    r = real'(n) * q;
    if (r >= pow2(EMAX + 1)) return {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}, 4'b0101};
    if (r < pow2(EMIN))      return {s, {(W-1){1'b0}}, 4'b0011};
    e2 = 0;
    while (r >= pow2(e2 + 1)) e2++;
    while (r < pow2(e2)) e2--;
    n = $rtoi(r / pow2(e2 - FRAC_W)) - (1 << FRAC_W);
    return {s, EXP_W'(e2 + BIAS), FRAC_W'(n), 3'b000, inx};
  endfunction

  function automatic logic [W-1:0] rand_operand(input logic [W-1:0] near);
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = W'($urandom);
      1: v = near ^ W'($urandom_range(0, 7));
      2: v = {~near[W-1], near[W-2:0]};
      3: case ($urandom_range(0, 5))
           0: v = 16'h7C00;
           1: v = 16'hFC00;
           2: v = 16'h7E00;
           3: v = 16'h7D01;
           4: v = 16'h0000;
           default: v = 16'h8000;
         endcase
      4: v = {1'($urandom), EXP_W'($urandom_range(0, 2)), FRAC_W'($urandom)};
      5: v = {1'($urandom), EXP_W'($urandom_range(28, 30)), FRAC_W'($urandom)};
      default: v = {1'($urandom), EXP_W'($urandom_range(10, 20)), FRAC_W'($urandom)};
    endcase
    return v;
  endfunction

  // Scoreboard: results must appear in order and stay put while stalled.
  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        check("ret_0", 32'(bus.ret_0), 32'(exp_q[0][W+3:4]));
        check("ret_1", 32'(bus.ret_1), 32'(exp_q[0][3:0]));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end else begin
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                      input logic [W+3:0] want);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.arg_0    = a;
    bus.arg_1    = b;
    bus.arg_2    = op;
    for (int unsigned t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    check("send_accept", 32'(acc), 32'd1);
    if (acc) exp_q.push_back(want);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int unsigned i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic op; logic [15:0] r; logic [3:0] f; } vec_t;
  vec_t vecs[10] = '{
    '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'h0},
    '{16'h3C01, 16'h3C00, 1'b1, 16'h1400, 4'h0},
    '{16'h4200, 16'h4200, 1'b1, 16'h0000, 4'h0},
    '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'h1},
    '{16'h3C00, 16'h1200, 1'b0, 16'h3C01, 4'h1},
    '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5},
    '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'h8},
    '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'h0},
    '{16'h0400, 16'h0401, 1'b1, 16'h8000, 4'h3},
    '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'h0}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic         op;
    logic         rnd_done;
    int unsigned  lat, base;

    bus.in_valid  = 1'b0;
    bus.arg_0     = '0;
    bus.arg_1     = '0;
    bus.arg_2     = 1'b0;
    bus.out_ready = 1'b1;
    a = 16'h3C00;

    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ret_0", 32'(bus.ret_0), 32'd0);
    check("rst_ret_1", 32'(bus.ret_1), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].op, {vecs[i].r, vecs[i].f});
    drain("drain_directed");

    // Latency: accepting edge counts as the first of four.
    send(16'h3C00, 16'h4000, 1'b0, {16'h4200, 4'h0});
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 32'd4);
    drain("drain_latency");

    // Eight back-to-back ops with a three-cycle output stall in the middle.
    base = n_out;
    fork
      for (int unsigned i = 0; i < 8; i++) begin
        a  = rand_operand(a);
        b  = rand_operand(a);
        op = 1'($urandom);
        send(a, b, op, model(a, b, op));
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    check("bp_count", n_out - base, 32'd8);

    rnd_done = 1'b0;
    fork
      begin
        for (int unsigned i = 0; i < 300; i++) begin
          a  = rand_operand(a);
          b  = rand_operand(a);
          op = 1'($urandom);
          send(a, b, op, model(a, b, op));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk);
        #1 bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    bus.out_ready = 1'b1;
    drain("drain_random");

    // Reset with one result held at the output and three more behind it.
    bus.out_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) send(16'h3C00, W'(16'h3C00 + i), 1'b0, model(16'h3C00, W'(16'h3C00 + i), 1'b0));
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ret_0", 32'(bus.ret_0), 32'd0);
    check("midrst_ret_1", 32'(bus.ret_1), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send(16'hC000, 16'h3C00, 1'b1, {16'hC200, 4'h0});
    drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
